// File: rtl/ram_controller_pkg.sv
// Shared types and constants for the high-score keeper.
// Imported by the RAM, the controller top level and the bench.
package ram_controller_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int N_OUT  = 6;
   localparam logic [3:0] GAME_OVER = 4'b0100;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      CHECK = 2'd2,
      WRITE = 2'd3
   } state_t;
endpackage

// File: rtl/ram_controller_ram.sv
// 8x8 single-port synchronous RAM.
// Address and read data are both registered: reads take two clocks.
module ram_8x8
   import ram_controller_pkg::*;
(
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              we,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      addr_q <= addr;
      dout   <= mem[addr_q];
   end
endmodule

// File: rtl/ram_controller.sv
// High-score keeper: one best score per user, cleared on reset/scoreReset,
// updated on each game-over edge only when the new score is strictly higher.
module ram_controller
   import ram_controller_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] score,
   input  logic [3:0]        gameState,
   input  logic              scoreReset,
   input  logic [ADDR_W-1:0] user_ID,
   output logic [DATA_W-1:0] score0,
   output logic [DATA_W-1:0] score1,
   output logic [DATA_W-1:0] score2,
   output logic [DATA_W-1:0] score3,
   output logic [DATA_W-1:0] score4,
   output logic [DATA_W-1:0] score5
);
   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [3:0]        gs_prev;
   logic [DATA_W-1:0] s_lat;
   logic [ADDR_W-1:0] a_lat;
   logic [DATA_W-1:0] hs [N_OUT];
   logic              trig;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   assign trig = (gameState == GAME_OVER) && (gs_prev != GAME_OVER);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         INIT:  if (cnt == '1) state_nx = IDLE;
         IDLE:  if (trig) state_nx = CHECK;
         CHECK: state_nx = (s_lat > ram_dout) ? WRITE : IDLE;
         WRITE: state_nx = IDLE;
         default: state_nx = INIT;
      endcase
      if (scoreReset) state_nx = INIT;
   end

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = user_ID;
      ram_din  = '0;
      unique case (state)
         INIT: begin
            ram_we   = 1'b1;
            ram_addr = cnt;
         end
         WRITE: begin
            ram_we   = 1'b1;
            ram_addr = a_lat;
            ram_din  = s_lat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         gs_prev <= '0;
         s_lat   <= '0;
         a_lat   <= '0;
      end else begin
         gs_prev <= gameState;
         if (scoreReset || state != INIT) cnt <= '0;
         else                             cnt <= cnt + 1'b1;
         if (state == IDLE && trig && !scoreReset) begin
            s_lat <= score;
            a_lat <= user_ID;
         end
      end
   end

   // Mirror of RAM entries 0..5; users 6 and 7 live only in the RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_OUT; i++) hs[i] <= '0;
      end else if (scoreReset) begin
         for (int i = 0; i < N_OUT; i++) hs[i] <= '0;
      end else if (state == WRITE) begin
         for (int i = 0; i < N_OUT; i++)
            if (a_lat == i[ADDR_W-1:0]) hs[i] <= s_lat;
      end
   end

   assign score0 = hs[0];
   assign score1 = hs[1];
   assign score2 = hs[2];
   assign score3 = hs[3];
   assign score4 = hs[4];
   assign score5 = hs[5];

   ram_8x8 u_ram (
      .clk  (clk),
      .addr (ram_addr),
      .din  (ram_din),
      .we   (ram_we),
      .dout (ram_dout)
   );
endmodule

// File: tb/tb_ram_controller.sv
// Directed bench for ram_controller.
// Expected scores are kept in a local table updated by hand per step.
module tb_ram_controller;
   import ram_controller_pkg::*;

   logic       clk_tb = 1'b0;
   logic       rst;
   logic [7:0] score;
   logic [3:0] gameState;
   logic       scoreReset;
   logic [2:0] user_ID;
   logic [7:0] score0, score1, score2, score3, score4, score5;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_hs [6];

   always #5 clk_tb = ~clk_tb;

   ram_controller dut (
      .clk        (clk_tb),
      .rst        (rst),
      .score      (score),
      .gameState  (gameState),
      .scoreReset (scoreReset),
      .user_ID    (user_ID),
      .score0     (score0),
      .score1     (score1),
      .score2     (score2),
      .score3     (score3),
      .score4     (score4),
      .score5     (score5)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_tb);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input state_t exp);
      tests++;
      assert (dut.state === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, dut.state, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk8({tag, ".s0"}, score0, exp_hs[0]);
      chk8({tag, ".s1"}, score1, exp_hs[1]);
      chk8({tag, ".s2"}, score2, exp_hs[2]);
      chk8({tag, ".s3"}, score3, exp_hs[3]);
      chk8({tag, ".s4"}, score4, exp_hs[4]);
      chk8({tag, ".s5"}, score5, exp_hs[5]);
   endtask

   // Stable user for 4 clocks, one-clock game-over pulse, then settle.
   task automatic game_over(input logic [2:0] uid, input logic [7:0] sc,
                            input state_t after_check, input string tag);
      user_ID = uid;
      score   = sc;
      tick(4);
      gameState = GAME_OVER;
      tick(1);
      gameState = 4'h0;
      tick(1);
      chk_state({tag, ".fsm"}, after_check);
      tick(3);
   endtask

   initial begin
      rst = 1'b0;
      score = '0;
      gameState = '0;
      scoreReset = 1'b0;
      user_ID = '0;
      for (int i = 0; i < 6; i++) exp_hs[i] = '0;

      tick(2);
      chk_all("rst_held");
      rst = 1'b1;
      tick(10);
      chk_all("reset");
      chk_state("reset.fsm", IDLE);
      for (int i = 0; i < 8; i++)
         chk8($sformatf("ram_init[%0d]", i), dut.u_ram.mem[i], 8'h00);

      game_over(3'd3, 8'h1B, WRITE, "w3");
      exp_hs[3] = 8'h1B;
      chk_all("w3");

      game_over(3'd1, 8'hC8, WRITE, "w1");
      exp_hs[1] = 8'hC8;
      chk_all("w1");
      game_over(3'd5, 8'hE5, WRITE, "w5");
      exp_hs[5] = 8'hE5;
      chk_all("w5");

      game_over(3'd1, 8'h08, IDLE, "lower");
      chk_all("lower");
      game_over(3'd1, 8'hC8, IDLE, "equal");
      chk_all("equal");

      game_over(3'd6, 8'h77, WRITE, "w6");
      chk_all("w6");
      chk8("ram6", dut.u_ram.mem[6], 8'h77);

      // Held game-over: only the first edge counts.
      user_ID = 3'd2;
      score   = 8'hF0;
      tick(4);
      gameState = GAME_OVER;
      tick(4);
      exp_hs[2] = 8'hF0;
      chk_all("hold_first");
      score = 8'hFF;
      tick(6);
      gameState = 4'h0;
      tick(4);
      chk_all("hold_once");

      // Clear is visible right after the edge that samples scoreReset.
      scoreReset = 1'b1;
      tick(1);
      scoreReset = 1'b0;
      for (int i = 0; i < 6; i++) exp_hs[i] = '0;
      chk_all("clear");
      chk_state("clear.fsm", INIT);

      // Game-over pulse while INIT is still running.
      user_ID = 3'd3;
      score   = 8'h55;
      tick(2);
      gameState = GAME_OVER;
      tick(1);
      gameState = 4'h0;
      tick(10);
      chk_all("init_drop");
      chk_state("init_drop.fsm", IDLE);
      chk8("ram3_clr", dut.u_ram.mem[3], 8'h00);
      chk8("ram6_clr", dut.u_ram.mem[6], 8'h00);

      game_over(3'd3, 8'h01, WRITE, "after_clr");
      exp_hs[3] = 8'h01;
      chk_all("after_clr");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
